if_prefetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It generates fetch addresses and talks to the instruction memory over a req/ack handshake with variable latency. Returned words are buffered in a small prefetch queue, and the queue head is presented as {PC, instruction} to IF/ID. Hazard stalls hold the head; branch/jump redirects flush the queue and restart fetch.

---
 rtl/if_prefetch_unit.sv | 177 +++++++++++++++++
 tb/tb_if_prefetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_unit
// Brief    : Instruction-fetch stage. Issues word-aligned fetches over a
//            req/ack handshake, buffers returned words in a circular
//            prefetch queue and presents the head as {PC, instruction}.
//            Stalls hold the head; redirects flush and restart fetch.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  // IDLE: no request outstanding. WAIT: request for fpc outstanding.
  // DISCARD: request for a stale address outstanding; its data is dropped.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      fpc_q, fpc_d;
  logic [31:0]      disc_addr_q, disc_addr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  // Queue storage; contents are only meaningful under occ_q, so no reset.
  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];

  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occ_after_pop;
  logic [31:0]      redirect_target;
  logic [1:0]       redirect_pc_lsb_unused;

  // The two low address bits of a redirect are architecturally meaningless.
  assign redirect_target        = {redirect_pc[31:2], 2'b00};
  assign redirect_pc_lsb_unused = redirect_pc[1:0];

  // Head consumption: a redirect squashes the head instead of handing it on.
  always_comb begin
    pop           = out_valid && !stall && !redirect;
    occ_after_pop = occ_q - OCC_W'(pop);
  end

  // Next-state / fetch-PC logic. Redirect outranks everything but reset.
  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    disc_addr_d = disc_addr_q;
    push        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Issue only with a slot guaranteed free; the queue cannot overrun.
        if (!redirect && (occ_q != OCC_FULL)) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect) begin
          // An ack in the redirect cycle is simply dropped; otherwise the
          // old request must still be drained, so remember its address.
          if (imem_ack) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_DISCARD;
            disc_addr_d = fpc_q;
          end
        end else if (imem_ack) begin
          push  = 1'b1;
          fpc_d = fpc_q + 32'd4;
          // Chain straight into the next fetch when the post-push queue
          // still has room; this gives one word per cycle on zero-wait acks.
          if ((occ_after_pop + OCC_ONE) < OCC_FULL) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DISCARD: begin
        if (imem_ack) begin
          if (!redirect && (occ_after_pop != OCC_FULL)) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (redirect) begin
      fpc_d = redirect_target;
    end
  end

  // Queue pointer and occupancy bookkeeping; a redirect empties the queue.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      fpc_q       <= RESET_PC;
      disc_addr_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      disc_addr_q <= disc_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
    end
  end

  // Queue write port: store the fetched word with the PC it came from.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem_q[wr_ptr_q]    <= fpc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // Memory-side and IF/ID-side outputs; empty queue presents a nop bubble.
  always_comb begin
    imem_req  = (state_q != ST_IDLE);
    imem_addr = (state_q == ST_DISCARD) ? disc_addr_q : fpc_q;
    occupancy = occ_q;
    out_valid = (occ_q != '0);
    out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'h0000_0000;
    out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0000_0000;
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch_unit
// Brief    : Directed self-checking bench for if_prefetch_unit with a
//            variable-latency instruction memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  occupancy;

  // Memory responder controls: automatic latency model or manual drive.
  logic        auto_mem = 1'b1;
  int          lat = 0;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_rdata = 32'h0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = 32'h0;

  int tests = 0;
  int fails = 0;

  assign imem_ack   = auto_mem ? auto_ack   : man_ack;
  assign imem_rdata = auto_mem ? auto_rdata : man_rdata;

  if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory: acks after 'lat' wait cycles of a held request.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!imem_req) begin
        auto_ack = 1'b0;
        cnt = 0;
      end else if (cnt >= lat) begin
        auto_ack   = 1'b1;
        auto_rdata = mem_word(imem_addr);
        cnt = 0;
      end else begin
        auto_ack = 1'b0;
        cnt++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic found;

    // ---- Reset state ----
    tick(); tick();
    chk("rst_occ",   32'(occupancy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_req",   32'(imem_req),  32'd0);
    chk("rst_pc",    out_pc,         32'h0);
    chk("rst_instr", out_instr,      32'h0);

    // ---- Zero-wait streaming ----
    rst = 1'b1;
    tick();
    chk("t1_req",   32'(imem_req),  32'd1);
    chk("t1_addr0", imem_addr,      32'h0);
    chk("t1_nv",    32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_pc",    out_pc,         32'(4 * i));
      chk("t1_instr", out_instr,      mem_word(32'(4 * i)));
      chk("t1_occ",   32'(occupancy), 32'd1);
    end

    // ---- Stall until full, then drain with push/pop across wrap ----
    stall = 1'b1;
    repeat (10) tick();
    chk("t2_occ",   32'(occupancy), 32'd4);
    chk("t2_req",   32'(imem_req),  32'd0);
    chk("t2_pc",    out_pc,         32'h8);
    chk("t2_instr", out_instr,      mem_word(32'h8));
    stall = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t5_valid", 32'(out_valid), 32'd1);
      chk("t5_pc",    out_pc,         32'(32'hC + 4 * i));
      chk("t5_instr", out_instr,      mem_word(32'(32'hC + 4 * i)));
      if (i >= 1) chk("t5_occ", 32'(occupancy), 32'd2);
    end

    // ---- 3-cycle latency, redirect while waiting for 0x8 ----
    lat = 3;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
    end
    chk("t3_found8", 32'(found), 32'd1);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("t3_occ",   32'(occupancy), 32'd0);
    chk("t3_dreq",  32'(imem_req),  32'd1);
    chk("t3_daddr", imem_addr,      32'h8);
    for (int i = 0; i < 30 && !out_valid; i++) tick();
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_pc",    out_pc,         32'h40);
    chk("t3_instr", out_instr,      mem_word(32'h40));

    // ---- Redirect coincident with ack (manual memory) ----
    auto_mem = 1'b0;
    lat = 0;
    man_ack = 1'b0;
    rst = 1'b0;
    tick(); tick();
    chk("t4_rreq", 32'(imem_req), 32'd0);
    rst = 1'b1;
    tick();
    chk("t4_req0",  32'(imem_req), 32'd1);
    chk("t4_addr0", imem_addr,     32'h0);
    man_ack = 1'b1;
    man_rdata = mem_word(32'h0);
    tick();
    chk("t4_pc0",   out_pc,    32'h0);
    chk("t4_addr4", imem_addr, 32'h4);
    stall = 1'b1;
    man_rdata = mem_word(32'h4);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    man_ack = 1'b0;
    chk("t4_occ",   32'(occupancy), 32'd0);
    chk("t4_valid", 32'(out_valid), 32'd0);
    chk("t4_idle",  32'(imem_req),  32'd0);
    chk("t4_nop",   out_instr,      32'h0);
    tick();
    chk("t4_req",   32'(imem_req),  32'd1);
    chk("t4_addr",  imem_addr,      32'h100);
    chk("t4_occ2",  32'(occupancy), 32'd0);
    man_ack = 1'b1;
    man_rdata = mem_word(32'h100);
    tick();
    man_ack = 1'b0;
    chk("t4_pc",    out_pc,         32'h100);
    chk("t4_instr", out_instr,      mem_word(32'h100));
    chk("t4_occ3",  32'(occupancy), 32'd1);
    chk("t4_next",  imem_addr,      32'h104);

    // ---- Reset mid-WAIT with a late ack ----
    rst = 1'b0;
    man_ack = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_req",   32'(imem_req),  32'd0);
    chk("t6_occ",   32'(occupancy), 32'd0);
    rst = 1'b1;
    stall = 1'b0;
    tick();
    man_ack = 1'b0;
    chk("t6_occ2",  32'(occupancy), 32'd0);
    chk("t6_req2",  32'(imem_req),  32'd1);
    chk("t6_addr",  imem_addr,      32'h0);
    man_ack = 1'b1;
    man_rdata = mem_word(32'h0);
    tick();
    man_ack = 1'b0;
    chk("t6_pc",    out_pc,         32'h0);
    chk("t6_instr", out_instr,      mem_word(32'h0));
    chk("t6_occ3",  32'(occupancy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
